// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial input and parallel result bus of the 8N1 UART receiver.
// The slave side is the receiver; the master side drives the line and consumes bytes.
interface uart_receiver_if;
    logic       rx;
    logic [7:0] data_out;
    logic       valid;
    logic       framing_err;
    logic       busy;

    modport master (
        output rx,
        input  data_out,
        input  valid,
        input  framing_err,
        input  busy
    );

    modport slave (
        input  rx,
        output data_out,
        output valid,
        output framing_err,
        output busy
    );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with a two-flop input synchronizer.
// The start bit is confirmed half a bit in. After that, every sample lands in the
// middle of a bit. A good stop bit latches the byte and gives a one-cycle valid
// pulse. A bad stop bit gives a one-cycle framing_err pulse, and then the receiver
// waits for the line to go idle.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 8,
    parameter int CNT_W        = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_receiver_if.slave bus
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             rxS;

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bitIdx_q,  bitIdx_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       dataOut_q, dataOut_d;
    logic             valid_q,   valid_d;
    logic             ferr_q,    ferr_d;

    // Two-flop synchronizer. It resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.rx;
            sync2_q <= sync1_q;
        end
    end

    assign rxS = sync2_q;

    // Next-state logic: framing FSM, bit-period counter, shifter and output strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        dataOut_d = dataOut_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxS) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (!rxS) begin
                        state_d  = DATA;
                        bitIdx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    shift_d = {rxS, shift_q[7:1]};
                    if (bitIdx_q == 3'd7) begin
                        state_d  = STOP;
                        bitIdx_d = 3'd0;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rxS) begin
                        dataOut_d = shift_q;
                        valid_d   = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            WAIT_IDLE: begin
                cnt_d = '0;
                if (rxS) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                bitIdx_d = 3'd0;
            end
        endcase
    end

    // State and datapath registers. Reset drops any partial frame without a pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitIdx_q  <= 3'd0;
            shift_q   <= 8'h00;
            dataOut_q <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            dataOut_q <= dataOut_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.data_out    = dataOut_q;
    assign bus.valid       = valid_q;
    assign bus.framing_err = ferr_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receiver: the downstream partner of the team's `transmitter` block, consuming its `tx` line.
- Samples the serial line with an oversampling counter and validates start and stop bits.
- Presents each received byte on a parallel bus with a one-cycle `valid` strobe.
- Used for transmitter loopback verification and as the RX half of the serial link.

Parameters:
- CLKS_PER_BIT, 8: clk cycles per serial bit; must be even and ≥4. Must match the transmitter's bit period.
- CNT_W, 8: width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rx  input  1  serial line; idle high; LSB-first, 1 start bit (0), 8 data bits, 1 stop bit (1).
- data_out  output  8  last correctly framed byte; holds until the next good frame.
- valid  output  1  one-cycle pulse; data_out is new in the same cycle.
- framing_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; data_out=8'h00; valid=0; framing_err=0; busy=0.
  - Shift register, bit index and counter = 0.
  - Synchronizer flops = 1.
  - Takes effect mid-frame too; the partial byte is discarded with no pulse.
- Synchronizer: rx passes through 2 flops, giving rx_s. All decisions use rx_s only.
- States: IDLE, START, DATA, STOP, WAIT_IDLE. The counter resets to 0 on every state change.
- IDLE: rx_s==0 -> START.
- START: counter counts up.
  - At cnt==CLKS_PER_BIT/2-1, sample rx_s.
  - 0 -> DATA (bit_idx=0).
  - 1 -> IDLE; a glitch is rejected silently, with no error pulse.
- DATA: at cnt==CLKS_PER_BIT-1, the mid-bit point:
  - Shift rx_s in so that bit 0 is the first received bit.
  - Increment bit_idx.
  - After the 8th sample -> STOP.
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
  - 1: data_out<=shift register, valid=1 for exactly one cycle, -> IDLE.
  - 0: framing_err=1 for one cycle, data_out unchanged, -> WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then -> IDLE. This stops a break condition (line held low) from re-triggering continuously.
- valid and framing_err are registered and never both high in the same cycle.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets a start bit that immediately follows the stop bit be detected without loss.
- Latency: valid rises 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the first clk edge that samples rx low, within ±2 cycles (synchronizer and registration).
- No flow control. A consumer that misses a valid pulse loses nothing except the strobe; data_out still holds the byte.
- Counter width: cnt never exceeds CLKS_PER_BIT-1, so there is no wrap.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with rx toggling -> data_out=0x00, valid=0, framing_err=0, busy=0 throughout. Release -> still idle.
2. Loopback, single byte: transmitter (same bit period) tx->rx sends 0xAA -> exactly one valid pulse with data_out=0xAA, within the latency window. framing_err never asserts. busy falls after the pulse.
3. Back-to-back: drive 0xCC then 0x3F with no idle gap between stop and next start -> two valid pulses carrying 0xCC then 0x3F, no error.
4. Glitch rejection: pull rx low for CLKS_PER_BIT/2-2 cycles, then high -> returns to IDLE, no valid, no framing_err, data_out unchanged.
5. Framing error: send 0x55 with stop bit forced to 0 and rx held low for 3 bit periods -> one framing_err pulse, no valid, data_out keeps its previous value. The FSM stays in WAIT_IDLE until rx returns high; the next good frame 0x0F -> valid with data_out=0x0F.
6. Reset mid-frame: assert rst during data bit 4 of 0xF0 -> outputs reset immediately. A subsequent clean 0x81 is received correctly with a single valid pulse.
